seven_seg_scan: RTL

Parametrised multiplexed seven-segment driver, successor to the team's fixed 8-digit scanner. It takes a packed hex word, per-digit decimal points and blanks. Updates are double-buffered so a new value only takes effect at a frame boundary, which avoids tearing. It scans DIGITS common lines at a configurable dwell, adds 16-step brightness PWM and full 0–F decoding, and sits between the register/bus logic and the board's SEGOUT/SEGCOM pins.

---
 rtl/seven_seg_if.sv | 14 +
 rtl/seven_seg_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_if.sv
// Register-side bundle for seven_seg_scan: display word, per-digit dp/blank, load strobe and brightness.
// Handshake: load is a single-cycle strobe with no ready/backpressure; data/dp/blank are captured on any clk edge where load=1.
interface seven_seg_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic [3:0]          bright;

  modport master (output data, dp, blank, load, bright);
  modport slave  (input  data, dp, blank, load, bright);
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner with frame-aligned double buffering, 16-step PWM and 0-F decode.
// Optional leading-zero blanking is compiled in when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 4000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  seven_seg_if.slave        bus,
  output logic [7:0]        SEGOUT,
  output logic [DIGITS-1:0] SEGCOM,
  output logic              frame_start
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRESC_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [7:0]         SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0]  COM_OFF    = COM_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]   shd_blank_q, shd_blank_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   com_q, com_d;
  logic                frame_start_q, frame_start_d;

  logic                presc_wrap;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                cur_lz;
  logic [DIGITS-1:0]   com_sel;
  logic [DIGITS-1:0]   lz_digit;
  logic [7:0]          seg_lit;
  logic [DIGITS-1:0]   com_lit;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110010;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Scan timing: the frame boundary is the wrap of the last digit's dwell.
  always_comb begin
    presc_wrap = (presc_q == LAST_PRESC);
    boundary   = presc_wrap && (idx_q == LAST_IDX);
    presc_d    = presc_wrap ? '0 : presc_q + PRESC_ONE;
    idx_d      = idx_q;
    if (presc_wrap) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
    end
    pwm_d         = pwm_q + 4'd1;
    frame_start_d = boundary;
  end

  // A load on the boundary cycle still lets the previous pending value reach the shadow.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    shd_data_d   = shd_data_q;
    shd_dp_d     = shd_dp_q;
    shd_blank_d  = shd_blank_q;
    if (boundary && pend_valid_q) begin
      shd_data_d   = pend_data_q;
      shd_dp_d     = pend_dp_q;
      shd_blank_d  = pend_blank_q;
      pend_valid_d = 1'b0;
    end
    if (bus.load) begin
      pend_data_d  = bus.data;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
      pend_valid_d = 1'b1;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic lz_run;

  // lz_digit[i] refers to digit i counted from the left; the rightmost digit always shows.
  always_comb begin
    lz_run   = 1'b1;
    lz_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lz_run      = lz_run && (shd_data_q[4*(DIGITS-1-i) +: 4] == 4'h0);
      lz_digit[i] = lz_run && (i != DIGITS - 1);
    end
  end
`else
  assign lz_digit = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    com_sel   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib               = shd_data_q[4*(DIGITS-1-i) +: 4];
        cur_dp                = shd_dp_q[DIGITS-1-i];
        cur_blank             = shd_blank_q[DIGITS-1-i];
        cur_lz                = lz_digit[i];
        com_sel[DIGITS-1-i]   = 1'b1;
      end
    end
    seg_lit = {decode_hex(cur_nib) & ~{7{cur_lz}}, cur_dp};
    if (cur_blank) begin
      seg_lit = '0;
    end
    com_lit = (pwm_q <= bus.bright) ? com_sel : '0;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    com_d   = COM_ACTIVE_LOW ? ~com_lit : com_lit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_valid_q  <= 1'b0;
      shd_data_q    <= '0;
      shd_dp_q      <= '0;
      shd_blank_q   <= '0;
      seg_q         <= SEG_OFF;
      com_q         <= COM_OFF;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      shd_data_q    <= shd_data_d;
      shd_dp_q      <= shd_dp_d;
      shd_blank_q   <= shd_blank_d;
      seg_q         <= seg_d;
      com_q         <= com_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign SEGOUT      = seg_q;
  assign SEGCOM      = com_q;
  assign frame_start = frame_start_q;

endmodule
